// File: rtl/seven_seg_pkg.sv
// Shared constants, FSM state type and leading-zero helper for the
// seven-segment scan controller.
package seven_seg_pkg;

  localparam int MAX_DIGITS = 16;

  localparam logic [6:0]            SEG_OFF = 7'h7F;
  localparam logic [MAX_DIGITS-1:0] AN_OFF  = '1;

  typedef enum logic {
    DEAD  = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Bit k set when digit k is a leading zero: every nibble j >= k is zero.
  // Digit 0 is never blanked.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [4*MAX_DIGITS-1:0] frame,
    input int                      num_digits
  );
    logic [MAX_DIGITS-1:0] m;
    logic                  seen_nz;
    m       = '0;
    seen_nz = 1'b0;
    for (int k = MAX_DIGITS-1; k >= 1; k--) begin
      if (k < num_digits) begin
        seen_nz = seen_nz | (frame[4*k +: 4] != 4'h0);
        m[k]    = ~seen_nz;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/seven_seg_display_encoder.sv
// Hex nibble to seven-segment pattern, active-high, bit order {g,f,e,d,c,b,a}.
module seven_seg_display_encoder (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    unique case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit display with
// a double-buffered hex frame, dead-time anti-ghosting and leading-zero blanking.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SLOT_CYCLES = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lz_blank,
  output logic                    busy,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_END = CW'(DEAD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  scan_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_q, act_d, pend_q, pend_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic busy_q, busy_d;
  logic blank_q, blank_d;
  logic [6:0] seg_n_q, seg_n_d;
  logic dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;

  logic                    wrap;
  logic                    slot_end;
  logic [4*NUM_DIGITS-1:0] frame_sel;
  logic [NUM_DIGITS-1:0]   dp_sel;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [3:0]              nib;
  logic [6:0]              seg_raw;

  assign wrap     = (cnt_q == '0) && (idx_q == '0);
  assign slot_end = (cnt_q == CNT_LAST);

  // On the frame boundary the pending frame is what this slot must show,
  // so look at it directly rather than waiting for the copy into active.
  assign frame_sel  = wrap ? pend_q    : act_q;
  assign dp_sel     = wrap ? pend_dp_q : act_dp_q;
  assign blank_mask = NUM_DIGITS'(lz_mask((4*MAX_DIGITS)'(frame_sel), NUM_DIGITS));
  assign nib        = frame_sel[4*idx_q +: 4];

  seven_seg_display_encoder u_enc (
    .hex (nib),
    .seg (seg_raw)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DEAD:    if (cnt_q == DEAD_END) state_d = DRIVE;
      DRIVE:   if (slot_end)          state_d = DEAD;
      default: state_d = DEAD;
    endcase
  end

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    act_d     = wrap ? pend_q    : act_q;
    act_dp_d  = wrap ? pend_dp_q : act_dp_q;
    pend_d    = load ? value_in  : pend_q;
    pend_dp_d = load ? dp_in     : pend_dp_q;
    busy_d    = load ? 1'b1 : (wrap ? 1'b0 : busy_q);

    // Blank decision is taken once at slot start and held for the slot.
    blank_d = (cnt_q == '0) ? (lz_blank & blank_mask[idx_q]) : blank_q;

    an_n_d = AN_OFF[NUM_DIGITS-1:0];
    if (state_q == DRIVE && !blank_d) an_n_d[idx_q] = 1'b0;
    seg_n_d = blank_d ? SEG_OFF : ~seg_raw;
    dp_n_d  = ~(dp_sel[idx_q] & ~blank_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DEAD;
      cnt_q     <= '0;
      idx_q     <= '0;
      act_q     <= '0;
      act_dp_q  <= '0;
      pend_q    <= '0;
      pend_dp_q <= '0;
      busy_q    <= 1'b0;
      blank_q   <= 1'b0;
      seg_n_q   <= SEG_OFF;
      dp_n_q    <= 1'b1;
      an_n_q    <= AN_OFF[NUM_DIGITS-1:0];
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      act_q     <= act_d;
      act_dp_q  <= act_dp_d;
      pend_q    <= pend_d;
      pend_dp_q <= pend_dp_d;
      busy_q    <= busy_d;
      blank_q   <= blank_d;
      seg_n_q   <= seg_n_d;
      dp_n_q    <= dp_n_d;
      an_n_q    <= an_n_d;
    end
  end

  assign busy        = busy_q;
  assign seg_n       = seg_n_q;
  assign dp_n        = dp_n_q;
  assign an_n        = an_n_q;
  // Gated by reset so the pulse stays low while held in reset.
  assign frame_start = rst_n & wrap;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized and directed bench for seven_seg_scan_ctrl against a slot-level
// reference model of the display.
module tb_seven_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int SC = 8;
  localparam int DC = 2;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   value_in;
  logic [3:0]    dp_in;
  logic          load;
  logic          lz_blank;
  logic          busy;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [3:0]    an_n;
  logic          frame_start;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SLOT_CYCLES (SC),
    .DEAD_CYCLES (DC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value_in    (value_in),
    .dp_in       (dp_in),
    .load        (load),
    .lz_blank    (lz_blank),
    .busy        (busy),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .an_n        (an_n),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position in the scan plus frames, and expected outputs.
  int          m_cnt, m_idx;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_adp, m_pdp;
  logic        m_busy, m_blank;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_dp;
  logic        cur_lz = 1'b0;

  function automatic logic leading_zero(input logic [15:0] f, input int k);
    if (k == 0) return 1'b0;
    for (int j = k; j < ND; j++)
      if (f[4*j +: 4] != 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_idx = 0;
    m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0;
    m_busy = 1'b0; m_blank = 1'b0;
    m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
  endtask

  task automatic model_step(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic lz);
    logic        at_frame;
    logic [15:0] f;
    logic [3:0]  fd;
    logic        bl;
    at_frame = (m_cnt == 0) && (m_idx == 0);
    f  = at_frame ? m_pend : m_act;
    fd = at_frame ? m_pdp  : m_adp;
    bl = (m_cnt == 0) ? (lz && leading_zero(f, m_idx)) : m_blank;
    m_an  = (m_cnt >= DC && !bl) ? ~(4'b0001 << m_idx) : 4'hF;
    m_seg = bl ? 7'h7F : ~SEG_TAB[f[4*m_idx +: 4]];
    m_dp  = !(fd[m_idx] && !bl);
    m_blank = bl;
    if (at_frame) begin m_act = m_pend; m_adp = m_pdp; end
    if (ld) begin m_pend = v; m_pdp = d; end
    m_busy = ld ? 1'b1 : (at_frame ? 1'b0 : m_busy);
    if (m_cnt == SC-1) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % ND;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic check_all();
    chk("an_n",        32'(an_n),        32'(m_an));
    chk("seg_n",       32'(seg_n),       32'(m_seg));
    chk("dp_n",        32'(dp_n),        32'(m_dp));
    chk("busy",        32'(busy),        32'(m_busy));
    chk("frame_start", 32'(frame_start), 32'(rst_n && m_cnt == 0 && m_idx == 0));
    chk("one_anode",   32'($countones(~an_n) <= 1), 32'(1));
  endtask

  task automatic tick(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] d);
    rst_n = r; load = ld; value_in = v; dp_in = d; lz_blank = cur_lz;
    if (!r) model_reset();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    if (r) model_step(ld, v, d, cur_lz);
    else   model_reset();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic seek(input int c, input int i);
    int k = 0;
    while (!(m_cnt == c && m_idx == i) && k < 100) begin
      idle(1);
      k++;
    end
    chk("seek_timeout", 32'(k >= 100), 32'(0));
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; load = 1'b0; value_in = '0; dp_in = '0; lz_blank = 1'b0;

    // Reset, release, then a reset asserted mid-slot.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 16'h0, 4'h0);
    chk("rst_an", 32'(an_n), 32'hF);
    chk("rst_seg", 32'(seg_n), 32'h7F);
    idle(11);
    tick(1'b0, 1'b0, 16'h0, 4'h0);
    tick(1'b0, 1'b0, 16'h0, 4'h0);
    chk("midrst_an", 32'(an_n), 32'hF);
    idle(3);

    // Scan order with a decimal point on digit 2.
    tick(1'b1, 1'b1, 16'h1234, 4'b0100);
    chk("busy_after_load", 32'(busy), 32'(1));
    idle(2*ND*SC);

    // Load during digit 2 DRIVE must not tear the current frame.
    seek(DC+1, 2);
    tick(1'b1, 1'b1, 16'hABCD, 4'b0001);
    idle(2*ND*SC);

    // Second load lands exactly on the frame boundary.
    tick(1'b1, 1'b1, 16'h5555, 4'b0000);
    seek(0, 0);
    tick(1'b1, 1'b1, 16'h6666, 4'b1000);
    chk("busy_held", 32'(busy), 32'(1));
    idle(2*ND*SC);

    // Leading-zero blanking.
    cur_lz = 1'b1;
    tick(1'b1, 1'b1, 16'h0070, 4'b1111);
    idle(2*ND*SC);
    tick(1'b1, 1'b1, 16'h0000, 4'b1111);
    idle(2*ND*SC);
    cur_lz = 1'b0;
    idle(ND*SC);

    // Random loads, lz toggles and occasional resets.
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      v = v >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 49) == 0) cur_lz = ~cur_lz;
      tick(($urandom_range(0, 499) != 0), ($urandom_range(0, 15) == 0), v, 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
